// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Responder end of the 2-wide instruction-fetch memory interface. Holds a
// word-addressed instruction array, accepts a two-address read request per
// cycle and returns both words, their PCs and a valid pulse exactly
// READ_LATENCY cycles after the request cycle. In-flight reads can be killed.
// Misaligned or out-of-range slots return NOP_INSTR and raise their fault bit.
//
// Parameters:
//   XLEN          data / address width
//   DEPTH_WORDS   number of instruction words (power of 2)
//   READ_LATENCY  request-to-valid latency in cycles, 1..4
//   BASE_ADDR     byte address of word 0 (word aligned)
//   NOP_INSTR     word returned for faulting slots
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_ren                   read request strobe (no backpressure)
//   imem_addr0 / imem_addr1    byte addresses of slot 0 / slot 1
//   kill                       drops all in-flight and same-cycle requests
//   prog_we/prog_addr/prog_wdata  programming write port
//   imem_rdata0 / imem_rdata1  returned instruction words
//   imem_pc                    echoed request addresses, [0]=addr0, [1]=addr1
//   imem_valid                 one-cycle response pulse
//   imem_fault                 per-slot fault flags, qualified by imem_valid
//
// Optional feature, macro IMEM_STATS_EN:
//   stat_reads                 saturating count of accepted requests
//   stat_faults                saturating count of retired faulting responses
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH_WORDS  = 1024,
    parameter int              READ_LATENCY = 1,
    parameter logic [XLEN-1:0] BASE_ADDR    = 32'h0,
    parameter logic [XLEN-1:0] NOP_INSTR    = 32'hD503201F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_ren,
    input  logic [XLEN-1:0]      imem_addr0,
    input  logic [XLEN-1:0]      imem_addr1,
    input  logic                 kill,
    input  logic                 prog_we,
    input  logic [XLEN-1:0]      prog_addr,
    input  logic [XLEN-1:0]      prog_wdata,
    output logic [XLEN-1:0]      imem_rdata0,
    output logic [XLEN-1:0]      imem_rdata1,
    output logic [1:0][XLEN-1:0] imem_pc,
    output logic                 imem_valid,
    output logic [1:0]           imem_fault
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_faults
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Instruction array; not reset.
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Three decoders share one structure: [0]=slot 0, [1]=slot 1, [2]=prog.
    logic [XLEN-1:0] dec_addr  [3];
    logic [AW-1:0]   dec_idx   [3];
    logic [2:0]      dec_fault;

    assign dec_addr[0] = imem_addr0;
    assign dec_addr[1] = imem_addr1;
    assign dec_addr[2] = prog_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dec
            // One extra MSB catches the borrow when addr < BASE_ADDR.
            logic [XLEN:0] off_ext;
            assign off_ext       = {1'b0, dec_addr[gi]} - {1'b0, BASE_ADDR};
            assign dec_idx[gi]   = off_ext[AW+1:2];
            // off[1:0] also covers a BASE_ADDR that is itself misaligned.
            assign dec_fault[gi] = (dec_addr[gi][1:0] != 2'b00)
                                || (off_ext[1:0] != 2'b00)
                                || off_ext[XLEN]
                                || (off_ext[XLEN-1:AW+2] != '0);
        end
    endgenerate

    logic accept;
    assign accept = imem_ren && !kill;

    // Programming write; reads in the same cycle see the old word because
    // the pipeline captures mem[] with non-blocking semantics.
    always_ff @(posedge clk) begin
        if (prog_we && !dec_fault[2]) begin
            mem[dec_idx[2]] <= prog_wdata;
        end
    end

    // Response shift chain. Stage 0 is the registered array read; the last
    // stage drives the outputs directly. A stage only loads when a live
    // response moves into it, so outputs hold between responses.
    logic [READ_LATENCY-1:0] s_valid_reg;
    logic [1:0][XLEN-1:0]    s_word_reg  [READ_LATENCY];
    logic [1:0][XLEN-1:0]    s_pc_reg    [READ_LATENCY];
    logic [1:0]              s_fault_reg [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                s_valid_reg[k] <= 1'b0;
                s_word_reg[k]  <= '0;
                s_pc_reg[k]    <= '0;
                s_fault_reg[k] <= '0;
            end
        end else begin
            s_valid_reg[0] <= accept;
            if (accept) begin
                for (int s = 0; s < 2; s++) begin
                    s_word_reg[0][s] <= dec_fault[s] ? NOP_INSTR : mem[dec_idx[s]];
                end
                s_pc_reg[0]    <= {dec_addr[1], dec_addr[0]};
                s_fault_reg[0] <= dec_fault[1:0];
            end
            // kill also blocks the hand-off into later stages, so nothing
            // already in flight can retire after it.
            for (int k = 1; k < READ_LATENCY; k++) begin
                s_valid_reg[k] <= s_valid_reg[k-1] && !kill;
                if (s_valid_reg[k-1] && !kill) begin
                    s_word_reg[k]  <= s_word_reg[k-1];
                    s_pc_reg[k]    <= s_pc_reg[k-1];
                    s_fault_reg[k] <= s_fault_reg[k-1];
                end
            end
        end
    end

    assign imem_valid  = s_valid_reg[READ_LATENCY-1];
    assign imem_rdata0 = s_word_reg[READ_LATENCY-1][0];
    assign imem_rdata1 = s_word_reg[READ_LATENCY-1][1];
    assign imem_pc     = s_pc_reg[READ_LATENCY-1];
    assign imem_fault  = s_fault_reg[READ_LATENCY-1];

`ifdef IMEM_STATS_EN
    logic [31:0] stat_reads_reg;
    logic [31:0] stat_faults_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reads_reg  <= '0;
            stat_faults_reg <= '0;
        end else begin
            if (accept && (stat_reads_reg != 32'hFFFF_FFFF)) begin
                stat_reads_reg <= stat_reads_reg + 32'd1;
            end
            // Counted during the cycle the faulting response is presented.
            if (imem_valid && (imem_fault != 2'b00)
                && (stat_faults_reg != 32'hFFFF_FFFF)) begin
                stat_faults_reg <= stat_faults_reg + 32'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_reg;
    assign stat_faults = stat_faults_reg;
`endif

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the 2-wide instruction-fetch memory interface.
- Accepts a two-address read request from fetch (imem_ren, imem_addr0/1) and returns both instruction words, their PCs and imem_valid after a fixed, parameterised latency.
- Holds a word-addressed instruction array. The array can be written through a programming port (boot loader or testbench).
- Supports killing in-flight reads on a pipeline flush or redirect. Flags misaligned and out-of-range addresses.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, number of 32-bit instruction words (power of 2).
- READ_LATENCY, 1, cycles from an accepted request to imem_valid; legal range 1..4.
- BASE_ADDR, 32'h0, byte address of word 0.
- NOP_INSTR, 32'hD503201F, word returned for faulting slots.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- imem_ren, in, 1, read request strobe; one request per cycle, no backpressure.
- imem_addr0, in, XLEN, byte address of slot 0.
- imem_addr1, in, XLEN, byte address of slot 1.
- kill, in, 1, discards every in-flight and same-cycle request.
- prog_we, in, 1, array write enable.
- prog_addr, in, XLEN, write byte address.
- prog_wdata, in, XLEN, write data.
- imem_rdata0, out, XLEN, slot 0 instruction.
- imem_rdata1, out, XLEN, slot 1 instruction.
- imem_pc, out, [1:0][XLEN-1:0], echoed request addresses; [0] = addr0, [1] = addr1.
- imem_valid, out, 1, response valid pulse.
- imem_fault, out, 2, per-slot fault flag; qualified by imem_valid.

Behaviour:
- Reset and clock:
  - Single clock domain. Reset is synchronous and active-high.
  - On reset: imem_valid=0, imem_fault=0, imem_rdata0/1=0, imem_pc=0, all pipeline valid bits cleared.
  - Array contents are not reset.
- Address decode, per slot:
  - off = addr - BASE_ADDR; idx = off[log2(DEPTH_WORDS)+1:2].
  - Fault if addr[1:0]!=0, if addr < BASE_ADDR, or if off >= DEPTH_WORDS*4.
  - A faulting slot returns NOP_INSTR with its imem_fault bit set. The other slot is unaffected.
- Read pipeline:
  - Request accepted at edge T when imem_ren=1, kill=0 and reset=0.
  - The array is read at T. Data, addresses and faults travel through a READ_LATENCY-deep shift chain.
  - Outputs are registered: imem_valid=1 in the cycle after edge T+READ_LATENCY-1, i.e. exactly READ_LATENCY cycles after the request cycle.
  - Back-to-back requests give back-to-back responses, in order, with no bubbles.
  - When no response retires, imem_valid=0; rdata, pc and fault hold their last values.
- Kill:
  - kill=1 clears every pipeline valid bit at the next edge, and the same-cycle request is not accepted.
  - imem_valid=0 for the following READ_LATENCY cycles, unless new requests are accepted after kill deasserts.
  - A request in the cycle after kill is serviced normally.
- Programming port:
  - prog_we=1 writes prog_wdata to idx(prog_addr) at the edge.
  - Misaligned or out-of-range writes are ignored.
  - A read and a write to the same word in the same cycle is read-before-write: the read returns the old data. The new data is visible to requests from the next cycle.
- Simultaneous events:
  - reset has priority over kill; kill has priority over imem_ren.
  - prog_we is independent of reads and of kill.
- addr1 is decoded independently of addr0; it is not required to equal addr0+4. Wrap past the array end faults slot 1 only.

Optional Feature:
- Macro: IMEM_STATS_EN.
- When defined, adds two outputs:
  - stat_reads, out, 32: count of accepted requests.
  - stat_faults, out, 32: count of retired responses with a nonzero imem_fault.
  - Both counters clear on reset and saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters do not exist. Remaining behaviour is identical.

Test Plan:
- Latency: READ_LATENCY=1; program words 0..3 = 11,22,33,44 (hex). Request addr0=0, addr1=4 at cycle 5 -> cycle 6: imem_valid=1, rdata0=11, rdata1=22, imem_pc={4,0}, fault=00. Repeat with READ_LATENCY=3 -> valid at cycle 8.
- Streaming: requests on 4 consecutive cycles at pc 0, 8, 0, 8 -> 4 consecutive valid pulses, in order, with matching pc and data; valid=0 afterwards.
- Kill: READ_LATENCY=3; requests at cycles 10 and 11, kill at cycle 12 -> no imem_valid in cycles 13..14. A request at cycle 13 -> valid at cycle 16.
- Faults: addr0=0x2 (misaligned), addr1=DEPTH_WORDS*4 -> valid with fault=11 and both rdata=D503201F. With addr0=0x0FFC, addr1=0x1000 (DEPTH 1024) -> fault=10, rdata0 = word 1023.
- Write/read collision: word 2 = AA; prog_we to 8 with BB and read addr0=8 in the same cycle -> response rdata0=AA; the next-cycle read returns BB.
- Reset mid-flight: READ_LATENCY=2, request at cycle 20, reset at cycle 21 -> no valid at cycle 22; all outputs 0. With IMEM_STATS_EN: stat_reads=0 after reset.
